// File: rtl/lcd_bus_arbiter_pkg.sv
// Shared types and constants for the HD44780 LCD bus arbiter.
// Contents: FSM state enum, HD44780 command/character bytes, 50 MHz timing
// defaults, and an index-width helper used by the interface and the RTL.
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    EXEC,
    DONE
  } arb_state_e;

  // HD44780 command / character bytes
  localparam logic [7:0] CMD_CLEAR  = 8'h01;
  localparam logic [7:0] CMD_LINE2  = 8'hC0;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

  // Timing defaults in 50 MHz clock cycles
  localparam int unsigned T40US = 2000;
  localparam int unsigned T1MS  = 50000;
  localparam int unsigned T2MS  = 100000;

  // Width of a requester index; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lcd_bus_arbiter_if.sv
// Requester-side and LCD-pin bundle for lcd_bus_arbiter.
//   req/req_rs/req_data/req_last : requester -> arbiter (byte i at [8*i+:8])
//   done/busy/grant_id           : arbiter -> requesters
//   lcd_data/lcd_rs/lcd_en/lcd_rw: arbiter -> LCD pins
// Modports: slave = arbiter side, master = requester/pin side.
interface lcd_bus_arbiter_if
  import lcd_pkg::*;
#(
  parameter int unsigned N_REQ = 2
);
  localparam int unsigned IDX_W = idx_w(N_REQ);

  logic [N_REQ-1:0]   req;
  logic [N_REQ-1:0]   req_rs;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   done;
  logic               busy;
  logic [IDX_W-1:0]   grant_id;
  logic [7:0]         lcd_data;
  logic               lcd_rs;
  logic               lcd_en;
  logic               lcd_rw;

  modport slave (
    input  req, req_rs, req_data, req_last,
    output done, busy, grant_id, lcd_data, lcd_rs, lcd_en, lcd_rw
  );

  modport master (
    output req, req_rs, req_data, req_last,
    input  done, busy, grant_id, lcd_data, lcd_rs, lcd_en, lcd_rw
  );

endinterface

// File: rtl/lcd_bus_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req_i   : request vector
//   ptr_i   : index with highest priority this round
//   valid_o : any request present
//   idx_o   : first set request at or after ptr_i, wrapping
module lcd_rr_pick
  import lcd_pkg::*;
#(
  parameter int unsigned N_REQ = 2,
  localparam int unsigned IDX_W = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  always_comb begin
    int unsigned cand;
    logic [IDX_W-1:0] cand_idx;
    logic found;
    valid_o  = 1'b0;
    idx_o    = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand     = (32'(ptr_i) + k) % N_REQ;
      cand_idx = cand[IDX_W-1:0];
      if (!found && req_i[cand_idx]) begin
        found = 1'b1;
        idx_o = cand_idx;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Round-robin arbiter and write sequencer for a shared HD44780 write bus.
// Each granted write runs SETUP (en low) -> PULSE (en high) -> EXEC (en low)
// -> DONE (one-cycle done pulse to the winner). rs/data are latched in the
// grant cycle and held until the next grant.
// Ports: clk, reset (sync, active-high), bus (lcd_bus_arbiter_if.slave).
// Optional macro LCD_ARB_BURST_EN: keeps a requester granted until the write
// carrying req_last=1 (or until it drops req).
module lcd_bus_arbiter
  import lcd_pkg::*;
#(
  parameter int unsigned N_REQ     = 2,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned SETUP_CYC = T40US,
  parameter int unsigned EN_CYC    = T1MS,
  parameter int unsigned EXEC_CYC  = T2MS
) (
  input logic              clk,
  input logic              reset,
  lcd_bus_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = idx_w(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || CNT_W == 0 || SETUP_CYC == 0 ||
      EN_CYC == 0 || EXEC_CYC == 0) begin : g_bad_param
    $error("lcd_bus_arbiter: illegal parameter value");
  end

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic             busy_q, busy_d;
  logic             en_q, en_d;
  logic             rs_q, rs_d;
  logic [7:0]       data_q, data_d;
  logic [N_REQ-1:0] done_q, done_d;
`ifdef LCD_ARB_BURST_EN
  logic             lock_q, lock_d;
  logic             last_q, last_d;
  logic             win_last;
`endif

  logic             pick_vld;
  logic [IDX_W-1:0] pick_idx;
  logic             win_vld;
  logic [IDX_W-1:0] win_idx;
  logic             win_rs;
  logic [7:0]       win_data;
  logic [IDX_W-1:0] ptr_adv;

  lcd_rr_pick #(
    .N_REQ(N_REQ)
  ) u_pick (
    .req_i  (bus.req),
    .ptr_i  (ptr_q),
    .valid_o(pick_vld),
    .idx_o  (pick_idx)
  );

  assign ptr_adv = (grant_q == IDX_W'(N_REQ - 1)) ? '0 : grant_q + IDX_W'(1);

  // Winner selection; a held burst lock bypasses the picker.
  always_comb begin
    win_vld  = pick_vld;
    win_idx  = pick_idx;
`ifdef LCD_ARB_BURST_EN
    if (lock_q && bus.req[grant_q]) begin
      win_vld = 1'b1;
      win_idx = grant_q;
    end
    win_last = 1'b0;
`endif
    win_rs   = 1'b0;
    win_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (win_idx == IDX_W'(i)) begin
        win_rs   = bus.req_rs[i];
        win_data = bus.req_data[8*i +: 8];
`ifdef LCD_ARB_BURST_EN
        win_last = bus.req_last[i];
`endif
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    ptr_d   = ptr_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    en_d    = en_q;
    rs_d    = rs_q;
    data_d  = data_q;
    done_d  = '0;
`ifdef LCD_ARB_BURST_EN
    lock_d  = lock_q;
    last_d  = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
`ifdef LCD_ARB_BURST_EN
        if (lock_q && !bus.req[grant_q]) lock_d = 1'b0;
`endif
        if (win_vld) begin
          grant_d = win_idx;
          rs_d    = win_rs;
          data_d  = win_data;
          busy_d  = 1'b1;
          state_d = SETUP;
`ifdef LCD_ARB_BURST_EN
          last_d  = win_last;
`endif
        end
      end
      SETUP: begin
        if (cnt_q == CNT_W'(SETUP_CYC - 1)) begin
          state_d = PULSE;
          cnt_d   = '0;
          en_d    = 1'b1;
        end
      end
      PULSE: begin
        if (cnt_q == CNT_W'(EN_CYC - 1)) begin
          state_d = EXEC;
          cnt_d   = '0;
          en_d    = 1'b0;
        end
      end
      EXEC: begin
        if (cnt_q == CNT_W'(EXEC_CYC - 1)) begin
          state_d         = DONE;
          cnt_d           = '0;
          done_d[grant_q] = 1'b1;
        end
      end
      DONE: begin
        cnt_d   = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
`ifdef LCD_ARB_BURST_EN
        // Lock only while the burst is unfinished and still requested;
        // the pointer stays put so the burst owner keeps its turn.
        if (!last_q && bus.req[grant_q]) begin
          lock_d = 1'b1;
        end else begin
          lock_d = 1'b0;
          ptr_d  = ptr_adv;
        end
`else
        ptr_d = ptr_adv;
`endif
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= '0;
      done_q  <= '0;
`ifdef LCD_ARB_BURST_EN
      lock_q  <= 1'b0;
      last_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      en_q    <= en_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      done_q  <= done_d;
`ifdef LCD_ARB_BURST_EN
      lock_q  <= lock_d;
      last_q  <= last_d;
`endif
    end
  end

  assign bus.done     = done_q;
  assign bus.busy     = busy_q;
  assign bus.grant_id = grant_q;
  assign bus.lcd_data = data_q;
  assign bus.lcd_rs   = rs_q;
  assign bus.lcd_en   = en_q;
  assign bus.lcd_rw   = 1'b0;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Self-checking bench for lcd_bus_arbiter (N_REQ=2, SETUP=3, EN=4, EXEC=5).
// Requesters are modelled as byte queues; the expected grant order, timing
// and held bus values come from a behavioural model of the arbitration rules.
module tb_lcd_bus_arbiter;

  localparam int N = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  // requester model state
  int       cnt[N];
  bit       cur_req[N];
  bit       cur_rs[N];
  bit [7:0] cur_data[N];
  bit       cur_last[N];
  // arbitration model state
  int       m_ptr = 0;
  bit       m_lock = 1'b0;
  int       m_lock_id = 0;

  lcd_bus_arbiter_if #(.N_REQ(N)) bus ();

  lcd_bus_arbiter #(
    .N_REQ    (N),
    .CNT_W    (32),
    .SETUP_CYC(3),
    .EN_CYC   (4),
    .EXEC_CYC (5)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.req[i]          = cur_req[i];
      bus.req_rs[i]       = cur_rs[i];
      bus.req_data[8*i+:8] = cur_data[i];
      bus.req_last[i]     = cur_last[i];
    end
  endtask

  task automatic arm(input int i, input int n, input bit rs, input bit [7:0] d);
    cnt[i]      = n;
    cur_req[i]  = (n > 0);
    cur_rs[i]   = rs;
    cur_data[i] = d;
    cur_last[i] = (n == 1);
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) arm(i, 0, 1'b0, 8'h00);
  endtask

  // Winner = pending requester at the smallest forward distance from ptr.
  function automatic int pick(input int p);
    int best = -1;
    int bestd = N;
    for (int i = 0; i < N; i++) begin
      if (cur_req[i] && ((i - p + N) % N) < bestd) begin
        bestd = (i - p + N) % N;
        best  = i;
      end
    end
    return best;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    clear_reqs();
    drive();
    @(negedge clk);
    @(negedge clk);
    chk("rst_en", 32'(bus.lcd_en), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_grant", 32'(bus.grant_id), 0);
    chk("rst_data", 32'(bus.lcd_data), 0);
    chk("rst_rs", 32'(bus.lcd_rs), 0);
    reset = 1'b0;
    m_ptr = 0;
    m_lock = 1'b0;
  endtask

  // Called at an IDLE-cycle negedge with requests already driven; ends at
  // the following IDLE-cycle negedge.
  task automatic xfer(input int id, input int drop_at);
    bit [7:0] ed = cur_data[id];
    bit       er = cur_rs[id];
    bit       el = cur_last[id];
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 1) chk("grant_id", 32'(bus.grant_id), 32'(id));
      if (c <= 13) begin
        chk($sformatf("en_c%0d", c), 32'(bus.lcd_en), 32'(c >= 4 && c <= 7));
        chk($sformatf("done_c%0d", c), 32'(bus.done), (c == 13) ? (32'(1) << id) : 0);
        chk($sformatf("busy_c%0d", c), 32'(bus.busy), 1);
        chk("rw", 32'(bus.lcd_rw), 0);
      end else begin
        chk("busy_idle", 32'(bus.busy), 0);
        chk("done_idle", 32'(bus.done), 0);
      end
      chk($sformatf("data_c%0d", c), 32'(bus.lcd_data), 32'(ed));
      chk($sformatf("rs_c%0d", c), 32'(bus.lcd_rs), 32'(er));
      if (c == 6) begin
        cur_data[id] = 8'($urandom);
        cur_rs[id]   = 1'($urandom);
        drive();
      end
      if (c == drop_at) begin
        cur_req[id] = 1'b0;
        cnt[id] = 1;
        drive();
      end
      if (c == 13) begin
        if (cnt[id] > 0) cnt[id]--;
        cur_req[id]  = (cnt[id] > 0);
        cur_last[id] = (cnt[id] == 1);
        if (cnt[id] > 0) begin
          cur_data[id] = 8'($urandom);
          cur_rs[id]   = 1'($urandom);
        end
        drive();
      end
    end
`ifdef LCD_ARB_BURST_EN
    if (!el && cur_req[id]) begin
      m_lock = 1'b1;
      m_lock_id = id;
    end else begin
      m_lock = 1'b0;
      m_ptr = (id + 1) % N;
    end
`else
    if (el) m_ptr = (id + 1) % N;
    else m_ptr = (id + 1) % N;
`endif
  endtask

  task automatic run_episode(output int order[$]);
    int exp;
    order = {};
    while (cur_req[0] || cur_req[1]) begin
      exp = (m_lock && cur_req[m_lock_id]) ? m_lock_id : pick(m_ptr);
      order.push_back(exp);
      xfer(exp, 0);
    end
  endtask

  initial begin
    int order[$];
    int seen;
    clear_reqs();
    drive();

    // 1: single write from requester 0
    do_reset();
    arm(0, 1, 1'b1, 8'h41);
    drive();
    xfer(0, 0);

    // 2: both requesting from reset, two bytes each
    do_reset();
    arm(0, 2, 1'b0, 8'h01);
    arm(1, 2, 1'b1, 8'h20);
    drive();
    run_episode(order);
`ifdef LCD_ARB_BURST_EN
    chk("t2_order", 32'({order[0], order[1], order[2], order[3]} == {0, 0, 1, 1}), 1);
`else
    chk("t2_order", 32'({order[0], order[1], order[2], order[3]} == {0, 1, 0, 1}), 1);
`endif

    // 3: requester 1 drops req during PULSE; write still completes
    do_reset();
    arm(1, 1, 1'b0, 8'hC0);
    drive();
    xfer(1, 5);
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.busy) seen++;
    end
    chk("t3_no_regrant", 32'(seen), 0);

    // 4: reset in the second PULSE cycle
    do_reset();
    arm(0, 1, 1'b1, 8'h55);
    drive();
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk($sformatf("t4_en_c%0d", c), 32'(bus.lcd_en), 32'(c >= 4));
    end
    reset = 1'b1;
    clear_reqs();
    drive();
    @(negedge clk);
    chk("t4_en", 32'(bus.lcd_en), 0);
    chk("t4_busy", 32'(bus.busy), 0);
    chk("t4_done", 32'(bus.done), 0);
    chk("t4_grant", 32'(bus.grant_id), 0);
    reset = 1'b0;
    m_ptr = 0;
    m_lock = 1'b0;
    arm(1, 1, 1'b0, 8'hA5);
    drive();
    run_episode(order);
    chk("t4_regrant", 32'(order[0]), 1);

    // 5: three-byte sequence on 0 against two bytes on 1
    do_reset();
    arm(0, 3, 1'b0, 8'hC0);
    arm(1, 2, 1'b1, 8'h48);
    drive();
    run_episode(order);
`ifdef LCD_ARB_BURST_EN
    chk("t5_order", 32'({order[0], order[1], order[2], order[3], order[4]} == {0, 0, 0, 1, 1}), 1);
`else
    chk("t5_order", 32'({order[0], order[1], order[2], order[3], order[4]} == {0, 1, 0, 1, 0}), 1);
`endif

    // randomized episodes
    for (int e = 0; e < 25; e++) begin
      for (int i = 0; i < N; i++)
        arm(i, int'($urandom_range(0, 3)), 1'($urandom), 8'($urandom));
      if (!cur_req[0] && !cur_req[1]) arm(0, 1, 1'($urandom), 8'($urandom));
      drive();
      run_episode(order);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
